aes_decrypt_core: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197 §5.3): accepts a 128-bit ciphertext and key, runs on-chip key expansion, then applies ten inverse rounds at one round per clock. It is the decrypt-side counterpart of the encryption datapath in the AES engine and uses the same 128-bit state byte layout. A one-entry expanded-key cache skips key expansion when consecutive operations use the same key.

---
 rtl/aes_decrypt_core.sv | 232 +++++++++++++++++++++++
 tb/tb_aes_decrypt_core.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher: on-chip key expansion, one inverse round per clock,
// and a one-entry expanded-key cache that skips expansion when the key repeats.
module aes_decrypt_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    output logic         busy,
    output logic         done,
    output logic [127:0] plaintext
);

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL} fsm_t;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // a^254 by repeated squaring; this maps 0 to 0 as required.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] i;
        i = ginv(x);
        return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    fsm_t         fsm_reg, fsm_next;
    logic [127:0] rk_reg [0:10];
    logic [127:0] blk_reg;
    logic [3:0]   rnd_reg;
    logic         key_valid_reg;
    logic [127:0] cached_key_reg;
    logic         busy_reg, done_reg;
    logic [127:0] plaintext_reg;

    logic         cache_hit;
    logic         ld_en, kexp_en, init_en, round_en, final_en;
    logic [127:0] rk_cur, rk_prev, rk_new;
    logic [127:0] isr, isb, ark, imc;
    logic [31:0]  sub_word;

    assign cache_hit = key_valid_reg && (key == cached_key_reg);

    // rk_cur feeds the round add (rk[0] in FINAL, since rnd has counted down to 0);
    // rk_prev feeds key expansion.
    always_comb begin
        rk_cur  = '0;
        rk_prev = '0;
        for (int i = 0; i < 11; i++) begin
            if (rnd_reg == i[3:0]) rk_cur = rk_reg[i];
        end
        for (int i = 1; i < 11; i++) begin
            if (rnd_reg == i[3:0]) rk_prev = rk_reg[i-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_state_bytes
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
            assign isr[127-8*gi -: 8] = blk_reg[127-8*SRC -: 8];
            assign isb[127-8*gi -: 8] = sbox_inv(isr[127-8*gi -: 8]);
        end

        for (gi = 0; gi < 4; gi++) begin : g_inv_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = ark[127-32*gi -: 8];
            assign a1 = ark[119-32*gi -: 8];
            assign a2 = ark[111-32*gi -: 8];
            assign a3 = ark[103-32*gi -: 8];
            assign imc[127-32*gi -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            assign imc[119-32*gi -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            assign imc[111-32*gi -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            assign imc[103-32*gi -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end

        // SubWord(RotWord(w3)): byte gi of the rotated word is byte (gi+1)%4 of w3.
        for (gi = 0; gi < 4; gi++) begin : g_key_sbox
            assign sub_word[31-8*gi -: 8] = sbox_fwd(rk_prev[31-8*((gi+1)%4) -: 8]);
        end
    endgenerate

    assign ark = isb ^ rk_cur;

    always_comb begin
        logic [31:0] w0, w1, w2, w3;
        w0 = rk_prev[127:96] ^ sub_word ^ {rcon(rnd_reg), 24'h0};
        w1 = rk_prev[95:64] ^ w0;
        w2 = rk_prev[63:32] ^ w1;
        w3 = rk_prev[31:0]  ^ w2;
        rk_new = {w0, w1, w2, w3};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_reg <= IDLE;
        else        fsm_reg <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm_reg;
        ld_en    = 1'b0;
        kexp_en  = 1'b0;
        init_en  = 1'b0;
        round_en = 1'b0;
        final_en = 1'b0;
        case (fsm_reg)
            IDLE: begin
                if (start) begin
                    ld_en    = 1'b1;
                    fsm_next = cache_hit ? INIT : KEYEXP;
                end
            end
            KEYEXP: begin
                kexp_en = 1'b1;
                if (rnd_reg == 4'd10) fsm_next = INIT;
            end
            INIT: begin
                init_en  = 1'b1;
                fsm_next = ROUND;
            end
            ROUND: begin
                round_en = 1'b1;
                if (rnd_reg == 4'd1) fsm_next = FINAL;
            end
            FINAL: begin
                final_en = 1'b1;
                fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 11; i++) rk_reg[i] <= '0;
            blk_reg        <= '0;
            rnd_reg        <= '0;
            key_valid_reg  <= 1'b0;
            cached_key_reg <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            plaintext_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            if (ld_en) begin
                blk_reg        <= ciphertext;
                rk_reg[0]      <= key;
                cached_key_reg <= key;
                busy_reg       <= 1'b1;
                if (!cache_hit) begin
                    key_valid_reg <= 1'b0;
                    rnd_reg       <= 4'd1;
                end
            end
            if (kexp_en) begin
                for (int i = 1; i < 11; i++) begin
                    if (rnd_reg == i[3:0]) rk_reg[i] <= rk_new;
                end
                rnd_reg <= rnd_reg + 4'd1;
                if (rnd_reg == 4'd10) key_valid_reg <= 1'b1;
            end
            if (init_en) begin
                blk_reg <= blk_reg ^ rk_reg[10];
                rnd_reg <= 4'd9;
            end
            if (round_en) begin
                blk_reg <= imc;
                rnd_reg <= rnd_reg - 4'd1;
            end
            if (final_en) begin
                plaintext_reg <= ark;
                busy_reg      <= 1'b0;
                done_reg      <= 1'b1;
            end
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign plaintext = plaintext_reg;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed FIPS-197 vectors, cache/latency, busy-start, mid-op reset and random pairs
// whose ciphertext comes from a table-driven forward AES-128 model.
module tb_aes_decrypt_core;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic         busy;
    logic         done;
    logic [127:0] plaintext;

    int n_vec = 0;
    int n_err = 0;

    aes_decrypt_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key        (key),
        .ciphertext (ciphertext),
        .busy       (busy),
        .done       (done),
        .plaintext  (plaintext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [2047:0] tab;
        tab = SBOX;
        return tab[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [127:0] w, s, t;
        logic [31:0]  tw;
        logic [7:0]   rc, a0, a1, a2, a3;
        w  = k;
        s  = pt ^ k;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            tw = {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])} ^ {rc, 24'h0};
            w[127:96] = w[127:96] ^ tw;
            w[95:64]  = w[95:64] ^ w[127:96];
            w[63:32]  = w[63:32] ^ w[95:64];
            w[31:0]   = w[31:0] ^ w[63:32];
            rc = xt(rc);
            for (int b = 0; b < 16; b++) begin
                t[127-8*b -: 8] = sb(s[127-8*(4*(((b/4) + (b%4)) % 4) + (b%4)) -: 8]);
            end
            s = t;
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-32*c -: 8];
                    a1 = s[119-32*c -: 8];
                    a2 = s[111-32*c -: 8];
                    a3 = s[103-32*c -: 8];
                    s[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            s = s ^ w;
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done; lat counts edges after the start edge.
    task automatic run_op(input logic [127:0] k, input logic [127:0] c,
                          output logic [127:0] p, output int lat, output int bcnt);
        @(negedge clk);
        key        = k;
        ciphertext = c;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        key        = ~k;
        ciphertext = ~c;
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        p = plaintext;
        $display("op key=%h ct=%h pt=%h latency=%0d busy=%0d", k, c, p, lat, bcnt);
    endtask

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        logic [127:0] p, rk, rp, rc;
        int lat, bcnt, ndone, cyc;

        rst_n = 1'b0;
        start = 1'b0;
        key = '0;
        ciphertext = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_pt", plaintext, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", 128'(busy), 128'd0);

        run_op(K1, C1, p, lat, bcnt);
        check("c1_pt", p, P1);
        check("c1_lat", 128'(lat), 128'd21);
        check("c1_busy", 128'(bcnt), 128'd21);

        run_op(K1, C1, p, lat, bcnt);
        check("c1c_pt", p, P1);
        check("c1c_lat", 128'(lat), 128'd11);
        check("c1c_busy", 128'(bcnt), 128'd11);

        run_op(KB, CB, p, lat, bcnt);
        check("b_pt", p, PB);
        check("b_lat", 128'(lat), 128'd21);
        @(posedge clk);
        #1;
        check("done_width", 128'(done), 128'd0);
        check("pt_hold", plaintext, PB);

        // start held high for the whole operation, with ciphertext churning after the start edge
        @(negedge clk);
        key = KB;
        ciphertext = CB;
        start = 1'b1;
        ndone = 0;
        lat = 0;
        p = '0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            ciphertext = {$urandom, $urandom, $urandom, $urandom};
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    p = plaintext;
                    lat = cyc;
                    start = 1'b0;
                end
            end
        end
        $display("op busy-start key=%h pt=%h latency=%0d dones=%0d", KB, p, lat, ndone);
        check("spam_ndone", 128'(ndone), 128'd1);
        check("spam_pt", p, PB);
        check("spam_lat", 128'(lat), 128'd11);
        check("spam_idle", 128'(busy), 128'd0);

        // reset in the middle of an operation
        @(negedge clk);
        key = K1;
        ciphertext = C1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_done", 128'(done), 128'd0);
        check("mid_rst_pt", plaintext, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(K1, C1, p, lat, bcnt);
        check("post_rst_pt", p, P1);
        check("post_rst_lat", 128'(lat), 128'd21);

        rk = '0;
        for (int i = 0; i < 200; i++) begin
            if (i % 2 == 0) rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            rc = aes_enc(rk, rp);
            run_op(rk, rc, p, lat, bcnt);
            check("rand_pt", p, rp);
            check("rand_lat", 128'(lat), (i % 2 == 0) ? 128'd21 : 128'd11);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
